// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU issue-side arbitration logic.
package fpu_pkg;

  localparam int          FP_W = 32;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search starting at ptr; pure combinational, one-hot grant plus index.
// Latency: 0 cycles. Backpressure: none, caller decides whether the grant is taken.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int j;

  // Walk the rotation backwards so the requester closest to ptr overwrites the rest.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fadd_arbiter.sv
// Shares one fadd unit among NREQ requesters, round-robin, one op in flight, watchdog on the result.
// Latency: accept T, issue T+1, response T+2 with a combinational fadd. Backpressure: holds RESP until rsp_ready[gnt].
module fadd_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*FP_W-1:0] req_x1,
  input  logic [NREQ*FP_W-1:0] req_x2,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [FP_W-1:0]      rsp_y,
  output logic [FP_W-1:0]      fu_x1,
  output logic [FP_W-1:0]      fu_x2,
  output logic                 fu_ready,
  input  logic                 fu_valid,
  input  logic [FP_W-1:0]      fu_y,
  output logic                 err
);

  localparam int IW = $clog2(NREQ);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  arb_state_t      state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   rr_idx;
  logic [NREQ-1:0] rr_gnt;
  logic [WW-1:0]   wdog;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  assign req_ready = (state == IDLE) ? rr_gnt : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      wdog      <= '0;
      rsp_valid <= '0;
      rsp_y     <= '0;
      fu_x1     <= '0;
      fu_x2     <= '0;
      fu_ready  <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            gnt      <= rr_idx;
            fu_x1    <= req_x1[FP_W*rr_idx +: FP_W];
            fu_x2    <= req_x2[FP_W*rr_idx +: FP_W];
            fu_ready <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          fu_ready <= 1'b0;
          if (fu_valid) begin
            rsp_y     <= fu_y;
            rsp_valid <= ONE << gnt;
            state     <= RESP;
          end else begin
            wdog  <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          // A result arriving on the last watchdog cycle still beats the abort.
          if (fu_valid) begin
            rsp_y     <= fu_y;
            rsp_valid <= ONE << gnt;
            state     <= RESP;
          end else if (wdog == WW'(TIMEOUT - 1)) begin
            rsp_y     <= QNAN;
            err       <= 1'b1;
            rsp_valid <= ONE << gnt;
            state     <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[gnt]) begin
            rsp_valid <= '0;
            ptr       <= (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fadd_arbiter.sv
// Directed bench for fadd_arbiter; a small lookup-table fadd model answers in the bench itself.
module tb_fadd_arbiter;
  import fpu_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_x1;
  logic [NREQ*32-1:0]   req_x2;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [31:0]          rsp_y;
  logic [31:0]          fu_x1;
  logic [31:0]          fu_x2;
  logic                 fu_ready;
  logic                 fu_valid;
  logic [31:0]          fu_y;
  logic                 err;

  logic [1:0] fu_mode = 2'd1;   // 0: never answers, 1: same cycle, 2: three cycles after issue
  logic [3:0] dcnt = 4'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fadd_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .fu_x1     (fu_x1),
    .fu_x2     (fu_x2),
    .fu_ready  (fu_ready),
    .fu_valid  (fu_valid),
    .fu_y      (fu_y),
    .err       (err)
  );

  function automatic logic [31:0] fsum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h40400000}: return 32'h40800000;
      {32'h3F800000, 32'h40800000}: return 32'h40A00000;
      {32'h40A00000, 32'hC0400000}: return 32'h40000000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic logic [31:0] rr_x2(input int i);
    case (i)
      0:       return 32'h3F800000;
      1:       return 32'h40000000;
      2:       return 32'h40400000;
      default: return 32'h40800000;
    endcase
  endfunction

  function automatic logic [31:0] rr_y(input int i);
    case (i)
      0:       return 32'h40000000;
      1:       return 32'h40400000;
      2:       return 32'h40800000;
      default: return 32'h40A00000;
    endcase
  endfunction

  always_comb begin
    fu_valid = 1'b0;
    case (fu_mode)
      2'd1:    fu_valid = fu_ready;
      2'd2:    fu_valid = (dcnt == 4'd3);
      default: fu_valid = 1'b0;
    endcase
    fu_y = fsum(fu_x1, fu_x2);
  end

  always @(posedge clk) begin
    if (fu_ready) dcnt <= 4'd1;
    else if (dcnt != 4'd0 && dcnt < 4'd15) dcnt <= dcnt + 4'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_x1[32*i +: 32] = a;
    req_x2[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    req_x1 = '0;
    req_x2 = '0;
    do_reset();
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0000", rsp_valid); end
    checks++; if (fu_ready !== 1'b0) begin errors++; $display("FAIL reset_fu_ready: got %b exp 0", fu_ready); end
    checks++; if (fu_x1 !== 32'h0 || fu_x2 !== 32'h0) begin errors++; $display("FAIL reset_fu_x: got %h/%h exp 0/0", fu_x1, fu_x2); end
    checks++; if (rsp_y !== 32'h0) begin errors++; $display("FAIL reset_rsp_y: got %h exp 00000000", rsp_y); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
  endtask

  task automatic test_single();
    do_reset();
    fu_mode   = 2'd1;
    set_op(0, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0001;
    rsp_ready = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_accept: got %b exp 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    #1;
    checks++; if (fu_ready !== 1'b1) begin errors++; $display("FAIL single_issue: got %b exp 1", fu_ready); end
    checks++; if (fu_x1 !== 32'h3F800000 || fu_x2 !== 32'h40000000) begin errors++; $display("FAIL single_operands: got %h/%h exp 3f800000/40000000", fu_x1, fu_x2); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_rsp: got %b exp 0000", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b exp 0001", rsp_valid); end
    checks++; if (rsp_y !== 32'h40400000) begin errors++; $display("FAIL single_rsp_y: got %h exp 40400000", rsp_y); end
    step();
    checks++; if (rsp_valid !== 4'b0000 || fu_ready !== 1'b0) begin errors++; $display("FAIL single_idle: got rsp_valid=%b fu_ready=%b exp 0000/0", rsp_valid, fu_ready); end
    checks++; if (fu_x1 !== 32'h3F800000) begin errors++; $display("FAIL single_hold_x1: got %h exp 3f800000", fu_x1); end
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    fu_mode = 2'd1;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h3F800000, rr_x2(i));
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      g = k % NREQ;
      checks++; if (req_ready !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant_%0d: got %b exp %b", k, req_ready, 4'(1 << g)); end
      step();
      step();
      checks++; if (rsp_valid !== 4'(1 << g)) begin errors++; $display("FAIL rr_rsp_valid_%0d: got %b exp %b", k, rsp_valid, 4'(1 << g)); end
      checks++; if (rsp_y !== rr_y(g)) begin errors++; $display("FAIL rr_rsp_y_%0d: got %h exp %h", k, rsp_y, rr_y(g)); end
      step();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    fu_mode = 2'd1;
    set_op(1, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0010;
    rsp_ready = 4'b1101;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_accept_skip: got %b exp 0010", req_ready); end
    step();
    req_valid = 4'b1111;
    step();
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 4'b0010 || rsp_y !== 32'h40400000) begin errors++; $display("FAIL bp_hold_%0d: got %b/%h exp 0010/40400000", c, rsp_valid, rsp_y); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_accept_%0d: got %b exp 0000", c, req_ready); end
      step();
    end
    rsp_ready = 4'b1111;
    #1;
    step();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL bp_release: got %b exp 0000", rsp_valid); end
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_next_ptr: got %b exp 0100", req_ready); end
    req_valid = 4'b0000;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_drop_req: got %b exp 0000", req_ready); end
    step();
    checks++; if (fu_ready !== 1'b0) begin errors++; $display("FAIL bp_dropped_issue: got %b exp 0", fu_ready); end
  endtask

  task automatic test_timeout();
    do_reset();
    fu_mode = 2'd0;
    set_op(0, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0001;
    rsp_ready = 4'b0000;
    #1;
    step();
    req_valid = 4'b0000;
    #1;
    checks++; if (fu_ready !== 1'b1) begin errors++; $display("FAIL to_issue: got %b exp 1", fu_ready); end
    for (int c = 0; c < TIMEOUT; c++) begin
      step();
      checks++; if (rsp_valid !== 4'b0000 || err !== 1'b0) begin errors++; $display("FAIL to_wait_%0d: got %b/%b exp 0000/0", c, rsp_valid, err); end
    end
    step();
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL to_rsp_valid: got %b exp 0001", rsp_valid); end
    checks++; if (rsp_y !== 32'h7FC00000) begin errors++; $display("FAIL to_rsp_y: got %h exp 7fc00000", rsp_y); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b exp 1", err); end
    rsp_ready = 4'b1111;
    fu_mode   = 2'd1;
    step();
    set_op(1, 32'h3F800000, 32'h3F800000);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL to_good_accept: got %b exp 0010", req_ready); end
    step();
    req_valid = 4'b0000;
    step();
    checks++; if (rsp_y !== 32'h40000000 || rsp_valid !== 4'b0010) begin errors++; $display("FAIL to_good_rsp: got %h/%b exp 40000000/0010", rsp_y, rsp_valid); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b exp 1", err); end
    step();
  endtask

  task automatic test_reset_midop();
    bit seen;
    fu_mode = 2'd0;
    set_op(2, 32'h40A00000, 32'hC0400000);
    req_valid = 4'b0100;
    rsp_ready = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rm_accept: got %b exp 0100", req_ready); end
    step();
    req_valid = 4'b0000;
    step();
    checks++; if (fu_ready !== 1'b0 || fu_x1 !== 32'h40A00000) begin errors++; $display("FAIL rm_wait_hold: got %b/%h exp 0/40a00000", fu_ready, fu_x1); end
    rstn = 1'b0;
    step();
    checks++; if (rsp_valid !== 4'b0000 || fu_ready !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL rm_ctrl: got %b/%b/%b exp 0000/0/0000", rsp_valid, fu_ready, req_ready); end
    checks++; if (fu_x1 !== 32'h0 || fu_x2 !== 32'h0 || rsp_y !== 32'h0) begin errors++; $display("FAIL rm_data: got %h/%h/%h exp 0/0/0", fu_x1, fu_x2, rsp_y); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rm_err: got %b exp 0", err); end
    rstn    = 1'b1;
    fu_mode = 2'd1;
    seen    = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (|rsp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rm_no_rsp: got %b exp 0", seen); end
  endtask

  task automatic test_subtraction();
    int n;
    do_reset();
    fu_mode = 2'd2;
    set_op(3, 32'h40A00000, 32'hC0400000);
    req_valid = 4'b1000;
    rsp_ready = 4'b0000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL sub_skip_idle: got %b exp 1000", req_ready); end
    step();
    req_valid = 4'b0000;
    n = 1;
    while (rsp_valid === 4'b0000 && n < 20) begin
      step();
      n++;
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL sub_latency: got %0d exp 5", n); end
    checks++; if (rsp_valid !== 4'b1000 || rsp_y !== 32'h40000000) begin errors++; $display("FAIL sub_rsp: got %b/%h exp 1000/40000000", rsp_valid, rsp_y); end
    rsp_ready = 4'b1111;
    step();
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL sub_ptr_wrap: got %b exp 0001", req_ready); end
    req_valid = 4'b0000;
    rsp_ready = 4'b0000;
    step();
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_x1    = '0;
    req_x2    = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_midop();
    test_subtraction();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
